// File: rtl/liang_pkg.sv
// Shared types and lane-formatting helpers for the execute stage.
package liang_pkg;

   localparam int unsigned Xlen = 32;

   typedef enum logic [2:0] {FuAlu, FuLoad, FuStore, FuBranch, FuCsr} fu_op_e;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu, AluLui
   } alu_op_e;

   typedef enum logic [1:0] {MemByte = 2'd0, MemHalf = 2'd1, MemWord = 2'd2} mem_size_e;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} ex_state_e;

   typedef struct packed {
      logic [Xlen-1:0] pc;
      logic [31:0]     inst;
      logic [Xlen-1:0] dnpc;
      logic [4:0]      rd;
      logic            rd_wen;
      fu_op_e          fu_op;
      alu_op_e         alu_op;
      mem_size_e       mem_size;
      logic            mem_unsigned;
      logic            ebreak;
   } uop_info_t;

   typedef struct packed {
      uop_info_t       uop_info;
      logic [Xlen-1:0] rs1_data;
      logic [Xlen-1:0] rs2_data;
      logic [Xlen-1:0] imm;
   } idToEx_t;

   typedef struct packed {
      uop_info_t       uop_info;
      logic [Xlen-1:0] alu_res;
      logic [Xlen-1:0] lsu_res;
   } exToWb_t;

   function automatic logic [31:0] store_wdata(mem_size_e size, logic [31:0] data);
      logic [31:0] res;
      case (size)
         MemByte: res = {4{data[7:0]}};
         MemHalf: res = {2{data[15:0]}};
         default: res = data;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_wstrb(mem_size_e size, logic [1:0] off);
      logic [3:0] base;
      logic [6:0] shifted;
      case (size)
         MemByte: base = 4'b0001;
         MemHalf: base = 4'b0011;
         default: base = 4'b1111;
      endcase
      // Lanes pushed past byte 3 are dropped, so misaligned stores just lose strobes.
      shifted = {3'b000, base} << off;
      return shifted[3:0];
   endfunction

   function automatic logic [31:0] load_fmt(mem_size_e size, logic uns, logic [1:0] off,
                                            logic [31:0] rdata);
      logic [15:0] sh;
      logic [31:0] res;
      sh = 16'(rdata >> {off, 3'b000});
      case (size)
         MemByte: res = {{24{sh[7] & ~uns}}, sh[7:0]};
         MemHalf: res = {{16{sh[15] & ~uns}}, sh[15:0]};
         default: res = rdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational integer ALU for the execute stage.
module pipe_alu
   import liang_pkg::*;
(
   input  alu_op_e          alu_op_i,
   input  logic [Xlen-1:0]  operand_a_i,
   input  logic [Xlen-1:0]  operand_b_i,
   output logic [Xlen-1:0]  alu_res_o
);

   logic [4:0] shamt;
   assign shamt = operand_b_i[4:0];

   always_comb begin
      alu_res_o = '0;
      case (alu_op_i)
         AluAdd:  alu_res_o = operand_a_i + operand_b_i;
         AluSub:  alu_res_o = operand_a_i - operand_b_i;
         AluAnd:  alu_res_o = operand_a_i & operand_b_i;
         AluOr:   alu_res_o = operand_a_i | operand_b_i;
         AluXor:  alu_res_o = operand_a_i ^ operand_b_i;
         AluSll:  alu_res_o = operand_a_i << shamt;
         AluSrl:  alu_res_o = operand_a_i >> shamt;
         AluSra:  alu_res_o = $unsigned($signed(operand_a_i) >>> shamt);
         AluSlt:  alu_res_o = {{(Xlen-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
         AluSltu: alu_res_o = {{(Xlen-1){1'b0}}, operand_a_i < operand_b_i};
         AluLui:  alu_res_o = operand_b_i;
         default: alu_res_o = '0;
      endcase
   end

endmodule

// File: rtl/pipe_ex.sv
// Execute stage: ALU result plus one outstanding LSU transaction, handed to WB.
module pipe_ex
   import liang_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  idToEx_t          idToEx_i,
   input  logic             id_valid_i,
   output logic             ex_ready_o,
   output exToWb_t          exToWb_o,
   output logic             ex_valid_o,
   input  logic             wb_ready_i,
   output logic             lsu_req_valid_o,
   input  logic             lsu_req_ready_i,
   output logic [31:0]      lsu_req_addr_o,
   output logic             lsu_req_wen_o,
   output logic [31:0]      lsu_req_wdata_o,
   output logic [3:0]       lsu_req_wstrb_o,
   input  logic             lsu_rsp_valid_i,
   input  logic [31:0]      lsu_rsp_rdata_i,
   output logic             ex_fwd_valid_o,
   output logic [4:0]       ex_fwd_rd_o,
   output logic [XLEN-1:0]  ex_fwd_data_o
);

   ex_state_e         state_q;
   idToEx_t           uop_q;
   logic [XLEN-1:0]   lsu_res_q;

   uop_info_t         info;
   logic              is_load;
   logic              is_store;
   logic [XLEN-1:0]   operand_b;
   logic [XLEN-1:0]   alu_res;
   logic [1:0]        off;
   logic              accept;
   logic              new_is_mem;

   assign info     = uop_q.uop_info;
   assign is_load  = (info.fu_op == FuLoad);
   assign is_store = (info.fu_op == FuStore);
   assign off      = alu_res[1:0];

   // Memory ops form rs1+imm and LUI passes imm; ID muxes any other immediate into rs2_data.
   assign operand_b = (is_load || is_store || info.alu_op == AluLui) ? uop_q.imm
                                                                      : uop_q.rs2_data;

   pipe_alu u_alu (
      .alu_op_i    (info.alu_op),
      .operand_a_i (uop_q.rs1_data),
      .operand_b_i (operand_b),
      .alu_res_o   (alu_res)
   );

   assign ex_ready_o = (state_q == StIdle) || ((state_q == StOut) && wb_ready_i);
   assign accept     = ex_ready_o && id_valid_i;
   assign new_is_mem = (idToEx_i.uop_info.fu_op == FuLoad) ||
                       (idToEx_i.uop_info.fu_op == FuStore);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         uop_q     <= '0;
         lsu_res_q <= '0;
      end else begin
         case (state_q)
            StIdle, StOut: begin
               if (accept) begin
                  uop_q     <= idToEx_i;
                  lsu_res_q <= '0;
                  state_q   <= new_is_mem ? StReq : StOut;
               end else if (state_q == StOut && wb_ready_i) begin
                  state_q <= StIdle;
               end
            end
            StReq: begin
               if (lsu_req_ready_i) state_q <= StWait;
            end
            StWait: begin
               if (lsu_rsp_valid_i) begin
                  if (is_load) begin
                     lsu_res_q <= load_fmt(info.mem_size, info.mem_unsigned, off,
                                           lsu_rsp_rdata_i);
                  end
                  state_q <= StOut;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign lsu_req_valid_o = (state_q == StReq);
   assign lsu_req_addr_o  = alu_res;
   assign lsu_req_wen_o   = is_store;
   assign lsu_req_wdata_o = is_store ? store_wdata(info.mem_size, uop_q.rs2_data) : '0;
   assign lsu_req_wstrb_o = is_store ? store_wstrb(info.mem_size, off) : '0;

   assign ex_valid_o = (state_q == StOut);

   always_comb begin
      exToWb_o          = '0;
      exToWb_o.uop_info = info;
      exToWb_o.alu_res  = alu_res;
      exToWb_o.lsu_res  = lsu_res_q;
   end

   assign ex_fwd_valid_o = (state_q == StOut) && info.rd_wen && (info.rd != 5'd0);
   assign ex_fwd_rd_o    = info.rd;
   assign ex_fwd_data_o  = is_load ? lsu_res_q : alu_res;

endmodule

// File: tb/tb_pipe_ex.sv
// Bench for pipe_ex: directed scenarios, then randomized traffic against a transaction model.
module tb_pipe_ex;
   import liang_pkg::*;

   localparam int NRand = 300;
   localparam int Limit = 20000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   idToEx_t     idToEx_i = '0;
   logic        id_valid_i = 1'b0;
   logic        ex_ready_o;
   exToWb_t     exToWb_o;
   logic        ex_valid_o;
   logic        wb_ready_i = 1'b1;
   logic        lsu_req_valid_o;
   logic        lsu_req_ready_i = 1'b0;
   logic [31:0] lsu_req_addr_o;
   logic        lsu_req_wen_o;
   logic [31:0] lsu_req_wdata_o;
   logic [3:0]  lsu_req_wstrb_o;
   logic        lsu_rsp_valid_i = 1'b0;
   logic [31:0] lsu_rsp_rdata_i = '0;
   logic        ex_fwd_valid_o;
   logic [4:0]  ex_fwd_rd_o;
   logic [31:0] ex_fwd_data_o;

   pipe_ex #(.XLEN(32)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .idToEx_i        (idToEx_i),
      .id_valid_i      (id_valid_i),
      .ex_ready_o      (ex_ready_o),
      .exToWb_o        (exToWb_o),
      .ex_valid_o      (ex_valid_o),
      .wb_ready_i      (wb_ready_i),
      .lsu_req_valid_o (lsu_req_valid_o),
      .lsu_req_ready_i (lsu_req_ready_i),
      .lsu_req_addr_o  (lsu_req_addr_o),
      .lsu_req_wen_o   (lsu_req_wen_o),
      .lsu_req_wdata_o (lsu_req_wdata_o),
      .lsu_req_wstrb_o (lsu_req_wstrb_o),
      .lsu_rsp_valid_i (lsu_rsp_valid_i),
      .lsu_rsp_rdata_i (lsu_rsp_rdata_i),
      .ex_fwd_valid_o  (ex_fwd_valid_o),
      .ex_fwd_rd_o     (ex_fwd_rd_o),
      .ex_fwd_data_o   (ex_fwd_data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      idToEx_t     u;
      logic [31:0] alu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] lres;
      logic        is_load;
      logic        fwd_v;
      logic [31:0] fwd_d;
   } exp_t;

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc_cnt = 0;
   int   npop = 0;
   exp_t exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Memory contents seen by the random phase: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] m_alu(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                         logic [31:0] imm);
      int sh;
      sh = int'(b % 32);
      case (op)
         AluAdd:  return a + b;
         AluSub:  return a - b;
         AluAnd:  return a & b;
         AluOr:   return a | b;
         AluXor:  return a ^ b;
         AluSll:  return a << sh;
         AluSrl:  return a >> sh;
         AluSra:  return $unsigned($signed(a) >>> sh);
         AluSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         AluSltu: return (a < b) ? 32'd1 : 32'd0;
         AluLui:  return imm;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(mem_size_e sz, logic uns, logic [31:0] addr,
                                          logic [31:0] word);
      logic [31:0] v;
      v = word >> (8 * int'(addr % 4));
      if (sz == MemByte) begin
         v = v & 32'hFF;
         return uns ? v : (v ^ 32'h80) - 32'h80;
      end else if (sz == MemHalf) begin
         v = v & 32'hFFFF;
         return uns ? v : (v ^ 32'h8000) - 32'h8000;
      end
      return word;
   endfunction

   function automatic exp_t mk_exp(idToEx_t u);
      exp_t e;
      int   mask;
      logic st;
      e.u       = u;
      e.addr    = u.rs1_data + u.imm;
      e.is_load = (u.uop_info.fu_op == FuLoad);
      st        = (u.uop_info.fu_op == FuStore);
      e.alu     = (e.is_load || st) ? e.addr
                : m_alu(u.uop_info.alu_op, u.rs1_data, u.rs2_data, u.imm);
      e.wen     = st;
      mask      = (u.uop_info.mem_size == MemByte) ? 1 : (u.uop_info.mem_size == MemHalf) ? 3 : 15;
      e.wstrb   = st ? 4'((mask << (e.addr % 4)) & 15) : 4'd0;
      if (!st) e.wdata = 32'd0;
      else if (u.uop_info.mem_size == MemByte) e.wdata = (u.rs2_data & 32'hFF) * 32'h0101_0101;
      else if (u.uop_info.mem_size == MemHalf) e.wdata = (u.rs2_data & 32'hFFFF) * 32'h0001_0001;
      else e.wdata = u.rs2_data;
      e.lres  = e.is_load ? m_load(u.uop_info.mem_size, u.uop_info.mem_unsigned, e.addr,
                                   mem_word(e.addr)) : 32'd0;
      e.fwd_v = u.uop_info.rd_wen && (u.uop_info.rd != 5'd0);
      e.fwd_d = e.is_load ? e.lres : e.alu;
      return e;
   endfunction

   function automatic idToEx_t mk(fu_op_e fu, alu_op_e op, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] imm, logic [4:0] rd, mem_size_e sz, logic uns,
                                  logic [31:0] pc);
      idToEx_t u;
      u = '0;
      u.uop_info.pc           = pc;
      u.uop_info.inst         = pc ^ 32'h0000_0013;
      u.uop_info.dnpc         = pc + 32'd4;
      u.uop_info.rd           = rd;
      u.uop_info.rd_wen       = (fu != FuStore);
      u.uop_info.fu_op        = fu;
      u.uop_info.alu_op       = op;
      u.uop_info.mem_size     = sz;
      u.uop_info.mem_unsigned = uns;
      u.rs1_data              = a;
      u.rs2_data              = b;
      u.imm                   = imm;
      return u;
   endfunction

   function automatic idToEx_t rand_uop(int i);
      idToEx_t u;
      int      sel;
      u = '0;
      sel = int'($urandom_range(0, 7));
      u.uop_info.pc     = 32'h8000_0000 + 32'(i * 4);
      u.uop_info.inst   = $urandom;
      u.uop_info.dnpc   = u.uop_info.pc + 32'd4;
      u.uop_info.rd     = 5'($urandom);
      u.uop_info.rd_wen = 1'($urandom);
      u.uop_info.ebreak = ($urandom_range(0, 15) == 0);
      u.uop_info.alu_op = alu_op_e'(4'($urandom_range(0, 10)));
      u.uop_info.fu_op  = (sel < 4) ? FuAlu : (sel == 4) ? FuLoad : (sel == 5) ? FuStore
                        : (sel == 6) ? FuBranch : FuCsr;
      u.rs1_data = $urandom;
      u.rs2_data = $urandom;
      u.imm      = $urandom;
      if (sel == 4 || sel == 5) begin
         u.uop_info.alu_op       = AluAdd;
         u.uop_info.mem_size     = mem_size_e'(2'($urandom_range(0, 2)));
         u.uop_info.mem_unsigned = 1'($urandom);
         u.rs1_data = 32'h1000_0000 + 32'($urandom_range(0, 4095));
         u.imm      = 32'($urandom_range(0, 63));
         if (u.uop_info.mem_size == MemWord) begin
            u.rs1_data = u.rs1_data & 32'hFFFF_FFFC;
            u.imm      = u.imm & 32'hFFFF_FFFC;
         end
         if (sel == 5) u.uop_info.rd_wen = 1'b0;
      end
      return u;
   endfunction

   // Zero-wait memory op: accept now, then expect OUT exactly three cycles later.
   task automatic mem_seq(input idToEx_t u);
      id_valid_i = 1'b1;
      idToEx_i   = u;
      cyc();
      id_valid_i = 1'b0;
      #2 check_eq("mem_t1_valid", 32'(ex_valid_o), 32'd0);
      cyc();
      #2 check_eq("mem_t2_valid", 32'(ex_valid_o), 32'd0);
      cyc();
      #2 check_eq("mem_t3_valid", 32'(ex_valid_o), 32'd1);
   endtask

   task automatic drive_rand();
      idToEx_t u;
      logic    fire;
      for (int i = 0; i < NRand; i++) begin
         id_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) cyc();
         u          = rand_uop(i);
         id_valid_i = 1'b1;
         idToEx_i   = u;
         fire       = 1'b0;
         while (!fire && cyc_cnt < Limit) begin
            @(negedge clk_i);
            if (ex_ready_o) begin
               fire = 1'b1;
               exp_q.push_back(mk_exp(u));
            end
            cyc();
         end
      end
      id_valid_i = 1'b0;
   endtask

   task automatic resp_rand();
      logic        pend;
      int          lat;
      logic [31:0] paddr;
      exp_t        e;
      pend = 1'b0;
      lat  = 0;
      paddr = '0;
      forever begin
         cyc();
         lsu_req_ready_i = ($urandom_range(0, 2) != 0);
         wb_ready_i      = ($urandom_range(0, 3) != 0);
         if (pend) begin
            if (lat == 0) begin
               lsu_rsp_valid_i = 1'b1;
               lsu_rsp_rdata_i = mem_word(paddr);
               pend = 1'b0;
            end else begin
               lat--;
               lsu_rsp_valid_i = 1'b0;
               lsu_rsp_rdata_i = $urandom;
            end
         end else begin
            // Stray responses outside WAIT must be ignored.
            lsu_rsp_valid_i = ($urandom_range(0, 4) == 0);
            lsu_rsp_rdata_i = $urandom;
         end
         @(negedge clk_i);
         if (lsu_req_valid_o && lsu_req_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("req_without_uop", 32'd1, 32'd0);
            end else begin
               e = exp_q[0];
               check_eq("req_addr", lsu_req_addr_o, e.addr);
               check_eq("req_wen", 32'(lsu_req_wen_o), 32'(e.wen));
               check_eq("req_wdata", lsu_req_wdata_o, e.wdata);
               check_eq("req_wstrb", 32'(lsu_req_wstrb_o), 32'(e.wstrb));
            end
            pend  = 1'b1;
            lat   = int'($urandom_range(0, 2));
            paddr = lsu_req_addr_o;
         end
      end
   endtask

   task automatic mon_rand();
      exp_t e;
      while (npop < NRand && cyc_cnt < Limit) begin
         @(negedge clk_i);
         cyc_cnt++;
         if (ex_valid_o && wb_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("out_without_uop", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("r_pc", exToWb_o.uop_info.pc, e.u.uop_info.pc);
               check_eq("r_inst", exToWb_o.uop_info.inst, e.u.uop_info.inst);
               check_eq("r_dnpc", exToWb_o.uop_info.dnpc, e.u.uop_info.dnpc);
               check_eq("r_ebreak", 32'(exToWb_o.uop_info.ebreak), 32'(e.u.uop_info.ebreak));
               check_eq("r_alu", exToWb_o.alu_res, e.alu);
               if (e.is_load) check_eq("r_lsu", exToWb_o.lsu_res, e.lres);
               check_eq("r_fwd_v", 32'(ex_fwd_valid_o), 32'(e.fwd_v));
               if (e.fwd_v) begin
                  check_eq("r_fwd_rd", 32'(ex_fwd_rd_o), 32'(e.u.uop_info.rd));
                  check_eq("r_fwd_d", ex_fwd_data_o, e.fwd_d);
               end
            end
            npop++;
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (2) cyc();
      #2;
      check_eq("rst_ex_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rst_ex_ready", 32'(ex_ready_o), 32'd1);
      check_eq("rst_req_valid", 32'(lsu_req_valid_o), 32'd0);
      check_eq("rst_wstrb", 32'(lsu_req_wstrb_o), 32'd0);
      check_eq("rst_wdata", lsu_req_wdata_o, 32'd0);
      check_eq("rst_fwd_valid", 32'(ex_fwd_valid_o), 32'd0);
      check_eq("rst_alu", exToWb_o.alu_res, 32'd0);
      check_eq("rst_lsu", exToWb_o.lsu_res, 32'd0);
      rst_i = 1'b0;

      // Back-to-back ALU stream
      cyc();
      id_valid_i = 1'b1;
      idToEx_i   = mk(FuAlu, AluAdd, 32'd5, 32'd7, 32'd0, 5'd1, MemWord, 1'b0, 32'h10);
      #2 check_eq("s_ready0", 32'(ex_ready_o), 32'd1);
      cyc();
      idToEx_i = mk(FuAlu, AluAdd, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, MemWord, 1'b0, 32'h14);
      #2 check_eq("s_valid1", 32'(ex_valid_o), 32'd1);
      check_eq("s_res1", exToWb_o.alu_res, 32'd12);
      check_eq("s_ready1", 32'(ex_ready_o), 32'd1);
      cyc();
      idToEx_i = mk(FuAlu, AluAdd, 32'd2, 32'd3, 32'd0, 5'd3, MemWord, 1'b0, 32'h18);
      #2 check_eq("s_valid2", 32'(ex_valid_o), 32'd1);
      check_eq("s_res2", exToWb_o.alu_res, 32'd0);
      check_eq("s_ready2", 32'(ex_ready_o), 32'd1);
      cyc();
      id_valid_i = 1'b0;
      #2 check_eq("s_valid3", 32'(ex_valid_o), 32'd1);
      check_eq("s_res3", exToWb_o.alu_res, 32'd5);
      cyc();
      #2 check_eq("s_idle", 32'(ex_valid_o), 32'd0);

      // WB stall, then same-cycle accept on release
      id_valid_i = 1'b1;
      wb_ready_i = 1'b0;
      idToEx_i   = mk(FuAlu, AluAdd, 32'd1, 32'd1, 32'd0, 5'd4, MemWord, 1'b0, 32'h100);
      cyc();
      idToEx_i = mk(FuAlu, AluAdd, 32'd10, 32'd20, 32'd0, 5'd4, MemWord, 1'b0, 32'h104);
      #2 check_eq("st_valid", 32'(ex_valid_o), 32'd1);
      check_eq("st_res", exToWb_o.alu_res, 32'd2);
      check_eq("st_ready", 32'(ex_ready_o), 32'd0);
      repeat (4) begin
         cyc();
         #2 check_eq("st_hold_res", exToWb_o.alu_res, 32'd2);
         check_eq("st_hold_pc", exToWb_o.uop_info.pc, 32'h100);
         check_eq("st_hold_valid", 32'(ex_valid_o), 32'd1);
         check_eq("st_hold_ready", 32'(ex_ready_o), 32'd0);
      end
      wb_ready_i = 1'b1;
      #1 check_eq("st_rel_ready", 32'(ex_ready_o), 32'd1);
      cyc();
      id_valid_i = 1'b0;
      #2 check_eq("st_next_res", exToWb_o.alu_res, 32'd30);
      check_eq("st_next_pc", exToWb_o.uop_info.pc, 32'h104);
      cyc();
      #2 check_eq("st_idle", 32'(ex_valid_o), 32'd0);

      // LB unsigned then signed, zero-wait memory; response held high to test WAIT gating
      lsu_req_ready_i = 1'b1;
      lsu_rsp_valid_i = 1'b1;
      lsu_rsp_rdata_i = 32'h80AA_BBCC;
      for (int k = 0; k < 2; k++) begin
         id_valid_i = 1'b1;
         idToEx_i   = mk(FuLoad, AluAdd, 32'h1000, 32'd0, 32'd3, 5'd6, MemByte, (k == 0),
                         32'h200);
         cyc();
         id_valid_i = 1'b0;
         #2 check_eq("lb_req_valid", 32'(lsu_req_valid_o), 32'd1);
         check_eq("lb_addr", lsu_req_addr_o, 32'h1003);
         check_eq("lb_wen", 32'(lsu_req_wen_o), 32'd0);
         check_eq("lb_wstrb", 32'(lsu_req_wstrb_o), 32'd0);
         check_eq("lb_wdata", lsu_req_wdata_o, 32'd0);
         cyc();
         #2 check_eq("lb_wait_valid", 32'(ex_valid_o), 32'd0);
         cyc();
         #2 check_eq("lb_out_valid", 32'(ex_valid_o), 32'd1);
         check_eq("lb_res", exToWb_o.lsu_res, (k == 0) ? 32'h0000_0080 : 32'hFFFF_FF80);
         cyc();
      end

      // LW x5 forwarding
      mem_seq(mk(FuLoad, AluAdd, 32'h1000, 32'd0, 32'd0, 5'd5, MemWord, 1'b0, 32'h210));
      check_eq("lw_fwd_valid", 32'(ex_fwd_valid_o), 32'd1);
      check_eq("lw_fwd_rd", 32'(ex_fwd_rd_o), 32'd5);
      check_eq("lw_fwd_data", ex_fwd_data_o, 32'h80AA_BBCC);
      cyc();

      // SH with request backpressure
      lsu_req_ready_i = 1'b0;
      id_valid_i = 1'b1;
      idToEx_i   = mk(FuStore, AluAdd, 32'h2000, 32'h1234_ABCD, 32'd2, 5'd0, MemHalf, 1'b0,
                      32'h300);
      cyc();
      id_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) lsu_req_ready_i = 1'b1;
         #2 check_eq("sh_req_valid", 32'(lsu_req_valid_o), 32'd1);
         check_eq("sh_addr", lsu_req_addr_o, 32'h2002);
         check_eq("sh_wen", 32'(lsu_req_wen_o), 32'd1);
         check_eq("sh_wdata", lsu_req_wdata_o, 32'hABCD_ABCD);
         check_eq("sh_wstrb", 32'(lsu_req_wstrb_o), 32'hC);
         cyc();
      end
      #2 check_eq("sh_wait_req", 32'(lsu_req_valid_o), 32'd0);
      check_eq("sh_wait_valid", 32'(ex_valid_o), 32'd0);
      cyc();
      #2 check_eq("sh_out_valid", 32'(ex_valid_o), 32'd1);
      check_eq("sh_fwd_valid", 32'(ex_fwd_valid_o), 32'd0);
      cyc();

      // Reset while waiting for a load response
      lsu_rsp_valid_i = 1'b0;
      id_valid_i = 1'b1;
      idToEx_i   = mk(FuLoad, AluAdd, 32'h3000, 32'd0, 32'd0, 5'd7, MemWord, 1'b0, 32'h400);
      cyc();
      id_valid_i = 1'b0;
      cyc();
      #2 check_eq("rw_in_wait_req", 32'(lsu_req_valid_o), 32'd0);
      check_eq("rw_in_wait_valid", 32'(ex_valid_o), 32'd0);
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      lsu_rsp_valid_i = 1'b1;
      lsu_rsp_rdata_i = 32'hDEAD_BEEF;
      #2 check_eq("rw_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rw_ready", 32'(ex_ready_o), 32'd1);
      check_eq("rw_req_valid", 32'(lsu_req_valid_o), 32'd0);
      check_eq("rw_fwd_valid", 32'(ex_fwd_valid_o), 32'd0);
      check_eq("rw_lsu", exToWb_o.lsu_res, 32'd0);
      cyc();
      #2 check_eq("rw_ignored_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rw_ignored_ready", 32'(ex_ready_o), 32'd1);
      lsu_rsp_valid_i = 1'b0;

      // x0 destination never forwards; a real destination does
      id_valid_i = 1'b1;
      idToEx_i   = mk(FuAlu, AluAdd, 32'd4, 32'd4, 32'd0, 5'd0, MemWord, 1'b0, 32'h500);
      cyc();
      idToEx_i = mk(FuAlu, AluAdd, 32'd3, 32'd4, 32'd0, 5'd9, MemWord, 1'b0, 32'h504);
      #2 check_eq("x0_valid", 32'(ex_valid_o), 32'd1);
      check_eq("x0_fwd_valid", 32'(ex_fwd_valid_o), 32'd0);
      cyc();
      id_valid_i = 1'b0;
      #2 check_eq("x9_fwd_valid", 32'(ex_fwd_valid_o), 32'd1);
      check_eq("x9_fwd_rd", 32'(ex_fwd_rd_o), 32'd9);
      check_eq("x9_fwd_data", ex_fwd_data_o, 32'd7);
      cyc();

      // Randomized traffic with random backpressure and memory latency
      fork
         resp_rand();
      join_none
      fork
         drive_rand();
         mon_rand();
      join
      check_eq("rand_completed", 32'(npop), 32'(NRand));
      check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
